// File: rtl/router_switch_allocator_if.sv
// Request/grant bundle between the router input ports, the switch allocator and the crossbar.
// The slave modport is the allocator's view; the master modport drives requests.
interface router_switch_allocator_if #(
    parameter int unsigned NPORT = 5,
    parameter int unsigned SELW  = 3
);
    logic [NPORT-1:0]       req_valid;
    logic [NPORT*NPORT-1:0] req_dir;
    logic [NPORT-1:0]       req_tail;
    logic [NPORT-1:0]       out_ready;
    logic [NPORT-1:0]       grant;
    logic [NPORT-1:0]       out_valid;
    logic [NPORT*SELW-1:0]  out_sel;
    logic [NPORT-1:0]       dir_err;

    modport master (
        output req_valid, req_dir, req_tail, out_ready,
        input  grant, out_valid, out_sel, dir_err
    );

    modport slave (
        input  req_valid, req_dir, req_tail, out_ready,
        output grant, out_valid, out_sel, dir_err
    );
endinterface

// File: rtl/router_switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking from head flit to tail flit.
// Grants and crossbar selects are combinational; lock, owner and pointer state is registered.
module router_switch_allocator #(
    parameter int unsigned NPORT = 5,
    parameter int unsigned SELW  = 3
) (
    input logic                     clk,
    input logic                     rst_n,
    router_switch_allocator_if.slave sw
);
    typedef enum logic [0:0] {StFree, StLocked} state_e;

    state_e           state_q  [NPORT];
    logic [SELW-1:0]  owner_q  [NPORT];
    logic [SELW-1:0]  rr_ptr_q [NPORT];
    logic [NPORT-1:0] dir_err_q;

    logic [NPORT-1:0]      legal;
    logic [NPORT-1:0]      cand    [NPORT];
    logic [NPORT-1:0]      xfer;
    logic [SELW-1:0]       win     [NPORT];
    logic [SELW-1:0]       win_nxt [NPORT];
    logic [NPORT-1:0]      grant_c;
    logic [NPORT-1:0]      valid_c;
    logic [NPORT*SELW-1:0] sel_c;
    logic                  found;
    logic [SELW:0]         idx;
    logic [SELW:0]         nxt;

    always_comb begin
        legal = '0;
        for (int i = 0; i < NPORT; i++) begin
            legal[i] = sw.req_valid[i] && $onehot(sw.req_dir[i*NPORT +: NPORT]);
        end
    end

    // cand[o][i]: input i holds a legal request for output o.
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            cand[o] = '0;
            for (int i = 0; i < NPORT; i++) begin
                cand[o][i] = legal[i] & sw.req_dir[i*NPORT + o];
            end
        end
    end

    always_comb begin
        grant_c = '0;
        valid_c = '0;
        sel_c   = '0;
        xfer    = '0;
        found   = 1'b0;
        idx     = '0;
        nxt     = '0;
        for (int o = 0; o < NPORT; o++) begin
            found  = 1'b0;
            win[o] = '0;
            if (state_q[o] == StLocked) begin
                win[o] = owner_q[o];
                found  = cand[o][owner_q[o]];
            end else begin
                for (int k = 0; k < NPORT; k++) begin
                    idx = {1'b0, rr_ptr_q[o]} + (SELW+1)'(k);
                    if (idx >= (SELW+1)'(NPORT)) idx = idx - (SELW+1)'(NPORT);
                    if (!found && cand[o][idx[SELW-1:0]]) begin
                        found  = 1'b1;
                        win[o] = idx[SELW-1:0];
                    end
                end
            end
            xfer[o] = found && sw.out_ready[o] && rst_n;
            nxt = {1'b0, win[o]} + (SELW+1)'(1);
            if (nxt >= (SELW+1)'(NPORT)) nxt = '0;
            win_nxt[o] = nxt[SELW-1:0];
            if (xfer[o]) begin
                grant_c[win[o]]          = 1'b1;
                valid_c[o]               = 1'b1;
                sel_c[o*SELW +: SELW]    = win[o];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_err_q <= '0;
            for (int o = 0; o < NPORT; o++) begin
                state_q[o]  <= StFree;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
            end
        end else begin
            dir_err_q <= sw.req_valid & ~legal;
            for (int o = 0; o < NPORT; o++) begin
                // Pointer moves only when a packet completes, so fairness is per packet.
                if (xfer[o]) begin
                    case (state_q[o])
                        StFree: begin
                            if (sw.req_tail[win[o]]) begin
                                rr_ptr_q[o] <= win_nxt[o];
                            end else begin
                                state_q[o] <= StLocked;
                                owner_q[o] <= win[o];
                            end
                        end
                        StLocked: begin
                            if (sw.req_tail[win[o]]) begin
                                state_q[o]  <= StFree;
                                rr_ptr_q[o] <= win_nxt[o];
                            end
                        end
                        default: state_q[o] <= StFree;
                    endcase
                end
            end
        end
    end

    assign sw.grant     = grant_c;
    assign sw.out_valid = valid_c;
    assign sw.out_sel   = sel_c;
    assign sw.dir_err   = dir_err_q;
endmodule

// File: tb/tb_router_switch_allocator.sv
// Scenario bench for router_switch_allocator: each row drives one cycle of requests and
// queues the expected grant/valid/select/error picture, compared before the next edge.
module tb_router_switch_allocator;
    localparam logic [4:0] Z = 5'b00000;
    localparam logic [4:0] F = 5'b11111;

    typedef struct {
        logic [4:0]  v;
        logic [24:0] d;
        logic [4:0]  t;
        logic [4:0]  r;
        logic [4:0]  eg;
        logic [4:0]  eov;
        logic [14:0] esel;
        logic        ra;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [4:0]  err_pending = '0;
    logic [29:0] exp_q[$];

    router_switch_allocator_if #(.NPORT(5), .SELW(3)) sw ();

    router_switch_allocator #(.NPORT(5), .SELW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] oh(input int o);
        logic [4:0] r;
        r    = '0;
        r[o] = 1'b1;
        return r;
    endfunction

    function automatic logic [14:0] sl(input int o, input logic [2:0] v);
        logic [14:0] r;
        r = '0;
        r[o*3 +: 3] = v;
        return r;
    endfunction

    function automatic logic [24:0] dv(input logic [4:0] i4, input logic [4:0] i3,
                                       input logic [4:0] i2, input logic [4:0] i1,
                                       input logic [4:0] i0);
        return {i4, i3, i2, i1, i0};
    endfunction

    function automatic row_t mk(input logic [4:0] v, input logic [24:0] d, input logic [4:0] t,
                                input logic [4:0] r, input logic [4:0] eg, input logic [4:0] eov,
                                input logic [14:0] esel, input logic ra);
        row_t x;
        x.v = v; x.d = d; x.t = t; x.r = r;
        x.eg = eg; x.eov = eov; x.esel = esel; x.ra = ra;
        return x;
    endfunction

    // Drive one cycle of stimulus and queue what the outputs must show during it.
    task automatic step(input row_t x);
        logic [4:0] ill;
        @(posedge clk);
        #1;
        sw.req_valid = x.v;
        sw.req_dir   = x.d;
        sw.req_tail  = x.t;
        sw.out_ready = x.r;
        for (int i = 0; i < 5; i++) begin
            ill[i] = x.v[i] && ($countones(x.d[i*5 +: 5]) != 1);
        end
        exp_q.push_back({x.eg, x.eov, x.esel, rst_n ? err_pending : Z});
        err_pending = rst_n ? ill : Z;
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [29:0] exp, obs;
        rows.push_back(mk(5'b00001, dv(Z, Z, Z, Z, oh(4)), 5'b00001, F, Z, Z, '0, 1'b0));
        rows.push_back(mk(Z, '0, Z, F, Z, Z, '0, 1'b1));
        rows.push_back(mk(Z, '0, Z, F, Z, Z, '0, 1'b1));
        foreach (rows[k]) begin
            step(rows[k]);
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {sw.grant, sw.out_valid, sw.out_sel, sw.dir_err};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL test_reset[%0d]: grant/valid/sel/err got %b %b %h %b required %b %b %h %b",
                         k, obs[29:25], obs[24:20], obs[19:5], obs[4:0],
                         exp[29:25], exp[24:20], exp[19:5], exp[4:0]);
            end
            rst_n = rows[k].ra;
        end
    endtask

    task automatic test_single();
        row_t rows[$];
        logic [29:0] exp, obs;
        rows.push_back(mk(5'b00001, dv(Z, Z, Z, Z, oh(4)), 5'b00001, F,
                          5'b00001, 5'b10000, sl(4, 3'd0), 1'b1));
        rows.push_back(mk(5'b00011, dv(Z, Z, Z, oh(4), oh(4)), 5'b00011, F,
                          5'b00010, 5'b10000, sl(4, 3'd1), 1'b1));
        rows.push_back(mk(5'b00011, dv(Z, Z, Z, oh(4), oh(4)), 5'b00011, F,
                          5'b00001, 5'b10000, sl(4, 3'd0), 1'b1));
        foreach (rows[k]) begin
            step(rows[k]);
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {sw.grant, sw.out_valid, sw.out_sel, sw.dir_err};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL test_single[%0d]: grant/valid/sel/err got %b %b %h %b required %b %b %h %b",
                         k, obs[29:25], obs[24:20], obs[19:5], obs[4:0],
                         exp[29:25], exp[24:20], exp[19:5], exp[4:0]);
            end
            rst_n = rows[k].ra;
        end
    endtask

    task automatic test_round_robin();
        row_t rows[$];
        logic [29:0] exp, obs;
        rows.push_back(mk(5'b01010, dv(Z, oh(2), Z, oh(2), Z), 5'b01010, F,
                          5'b00010, 5'b00100, sl(2, 3'd1), 1'b1));
        rows.push_back(mk(5'b01000, dv(Z, oh(2), Z, Z, Z), 5'b01000, F,
                          5'b01000, 5'b00100, sl(2, 3'd3), 1'b1));
        rows.push_back(mk(5'b01011, dv(Z, oh(2), Z, oh(2), oh(2)), 5'b01011, F,
                          5'b00001, 5'b00100, sl(2, 3'd0), 1'b1));
        foreach (rows[k]) begin
            step(rows[k]);
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {sw.grant, sw.out_valid, sw.out_sel, sw.dir_err};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL test_round_robin[%0d]: grant/valid/sel/err got %b %b %h %b required %b %b %h %b",
                         k, obs[29:25], obs[24:20], obs[19:5], obs[4:0],
                         exp[29:25], exp[24:20], exp[19:5], exp[4:0]);
            end
            rst_n = rows[k].ra;
        end
    endtask

    task automatic test_wormhole();
        row_t rows[$];
        logic [29:0] exp, obs;
        logic [24:0] d3;
        d3 = dv(oh(0), Z, oh(0), oh(3), Z);
        rows.push_back(mk(5'b10110, d3, 5'b10010, F, 5'b00110, 5'b01001,
                          sl(0, 3'd2) | sl(3, 3'd1), 1'b1));
        rows.push_back(mk(5'b10110, d3, 5'b10010, F, 5'b00110, 5'b01001,
                          sl(0, 3'd2) | sl(3, 3'd1), 1'b1));
        rows.push_back(mk(5'b10110, d3, 5'b10110, F, 5'b00110, 5'b01001,
                          sl(0, 3'd2) | sl(3, 3'd1), 1'b1));
        rows.push_back(mk(5'b10010, dv(oh(0), Z, Z, oh(3), Z), 5'b10010, F, 5'b10010, 5'b01001,
                          sl(0, 3'd4) | sl(3, 3'd1), 1'b1));
        // Owner goes idle mid-packet: the output bubbles rather than serving in4.
        rows.push_back(mk(5'b10100, dv(oh(0), Z, oh(0), Z, Z), 5'b10000, F,
                          5'b00100, 5'b00001, sl(0, 3'd2), 1'b1));
        rows.push_back(mk(5'b10000, dv(oh(0), Z, oh(0), Z, Z), 5'b10000, F, Z, Z, '0, 1'b1));
        rows.push_back(mk(5'b10100, dv(oh(0), Z, oh(0), Z, Z), 5'b10100, F,
                          5'b00100, 5'b00001, sl(0, 3'd2), 1'b1));
        rows.push_back(mk(5'b10000, dv(oh(0), Z, Z, Z, Z), 5'b10000, F,
                          5'b10000, 5'b00001, sl(0, 3'd4), 1'b1));
        foreach (rows[k]) begin
            step(rows[k]);
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {sw.grant, sw.out_valid, sw.out_sel, sw.dir_err};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL test_wormhole[%0d]: grant/valid/sel/err got %b %b %h %b required %b %b %h %b",
                         k, obs[29:25], obs[24:20], obs[19:5], obs[4:0],
                         exp[29:25], exp[24:20], exp[19:5], exp[4:0]);
            end
            rst_n = rows[k].ra;
        end
    endtask

    task automatic test_backpressure();
        row_t rows[$];
        logic [29:0] exp, obs;
        for (int c = 0; c < 4; c++) begin
            rows.push_back(mk(5'b01000, dv(Z, oh(1), Z, Z, Z), Z, 5'b11101, Z, Z, '0, 1'b1));
        end
        rows.push_back(mk(5'b01000, dv(Z, oh(1), Z, Z, Z), Z, F,
                          5'b01000, 5'b00010, sl(1, 3'd3), 1'b1));
        rows.push_back(mk(5'b01001, dv(Z, oh(1), Z, Z, oh(1)), 5'b00001, 5'b11101,
                          Z, Z, '0, 1'b1));
        rows.push_back(mk(5'b01001, dv(Z, oh(1), Z, Z, oh(1)), 5'b01001, F,
                          5'b01000, 5'b00010, sl(1, 3'd3), 1'b1));
        rows.push_back(mk(5'b00001, dv(Z, Z, Z, Z, oh(1)), 5'b00001, F,
                          5'b00001, 5'b00010, sl(1, 3'd0), 1'b1));
        foreach (rows[k]) begin
            step(rows[k]);
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {sw.grant, sw.out_valid, sw.out_sel, sw.dir_err};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL test_backpressure[%0d]: grant/valid/sel/err got %b %b %h %b required %b %b %h %b",
                         k, obs[29:25], obs[24:20], obs[19:5], obs[4:0],
                         exp[29:25], exp[24:20], exp[19:5], exp[4:0]);
            end
            rst_n = rows[k].ra;
        end
    endtask

    task automatic test_dir_err();
        row_t rows[$];
        logic [29:0] exp, obs;
        rows.push_back(mk(5'b00010, dv(Z, Z, Z, Z, Z), Z, F, Z, Z, '0, 1'b1));
        rows.push_back(mk(5'b00011, dv(Z, Z, Z, 5'b00110, oh(2)), 5'b00001, F,
                          5'b00001, 5'b00100, sl(2, 3'd0), 1'b1));
        rows.push_back(mk(Z, dv(F, Z, Z, Z, Z), Z, F, Z, Z, '0, 1'b1));
        rows.push_back(mk(Z, '0, Z, F, Z, Z, '0, 1'b1));
        foreach (rows[k]) begin
            step(rows[k]);
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {sw.grant, sw.out_valid, sw.out_sel, sw.dir_err};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL test_dir_err[%0d]: grant/valid/sel/err got %b %b %h %b required %b %b %h %b",
                         k, obs[29:25], obs[24:20], obs[19:5], obs[4:0],
                         exp[29:25], exp[24:20], exp[19:5], exp[4:0]);
            end
            rst_n = rows[k].ra;
        end
    endtask

    task automatic test_reset_midpacket();
        row_t rows[$];
        logic [29:0] exp, obs;
        rows.push_back(mk(5'b00011, dv(Z, Z, Z, oh(2), oh(0)), 5'b00011, F, 5'b00011, 5'b00101,
                          sl(0, 3'd0) | sl(2, 3'd1), 1'b1));
        rows.push_back(mk(5'b10100, dv(oh(0), Z, oh(0), Z, Z), 5'b10000, F,
                          5'b00100, 5'b00001, sl(0, 3'd2), 1'b1));
        rows.push_back(mk(5'b11100, dv(oh(0), Z, oh(0), Z, Z), 5'b10000, F,
                          5'b00100, 5'b00001, sl(0, 3'd2), 1'b0));
        rows.push_back(mk(5'b11100, dv(oh(0), Z, oh(0), Z, Z), 5'b10000, F, Z, Z, '0, 1'b0));
        rows.push_back(mk(Z, '0, Z, F, Z, Z, '0, 1'b1));
        rows.push_back(mk(5'b11010, dv(oh(0), oh(2), Z, oh(2), Z), 5'b11010, F, 5'b10010, 5'b00101,
                          sl(0, 3'd4) | sl(2, 3'd1), 1'b1));
        foreach (rows[k]) begin
            step(rows[k]);
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = {sw.grant, sw.out_valid, sw.out_sel, sw.dir_err};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL test_reset_midpacket[%0d]: grant/valid/sel/err got %b %b %h %b required %b %b %h %b",
                         k, obs[29:25], obs[24:20], obs[19:5], obs[4:0],
                         exp[29:25], exp[24:20], exp[19:5], exp[4:0]);
            end
            rst_n = rows[k].ra;
        end
    endtask

    initial begin
        sw.req_valid = '0;
        sw.req_dir   = '0;
        sw.req_tail  = '0;
        sw.out_ready = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wormhole();
        test_backpressure();
        test_dir_err();
        test_reset_midpacket();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
